// File: rtl/index_buffer_pkg.sv
// Shared types and address helper for the triangle index buffer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package index_buffer_pkg;

  // Fetch sequencer states: idle, three RAM address issues, final capture.
  typedef enum logic [2:0] {
    IB_IDLE,
    IB_READ0,
    IB_READ1,
    IB_READ2,
    IB_CAPTURE
  } ib_state_t;

  // Flat index-word address of a triangle corner: three words per triangle.
  function automatic int unsigned tri_word_addr(input int unsigned tri_idx,
                                                input int unsigned corner);
    return 3 * tri_idx + corner;
  endfunction

endpackage

// File: rtl/index_ram.sv
// Simple dual-port index RAM: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en_i; a same-cycle write to the read address returns old data.
// Backpressure: none; both ports accept a request on every cycle.
module index_ram #(
  parameter int DEPTH = 49152,
  parameter int WIDTH = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read-before-write array with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/triangle_index_fetcher.sv
// Fetches the three vertex indices of the next triangle from the index RAM.
// Latency: o_index_dv 4 cycles after the accepting edge; one fetch per 5 cycles back-to-back.
// Backpressure: none; a request while busy is dropped and flagged on o_error.
module triangle_index_fetcher
  import index_buffer_pkg::*;
#(
  parameter int  MAX_TRIANGLE_COUNT = 16384,
  parameter int  MAX_VERTEX_COUNT   = 16384,
  localparam int TW = $clog2(MAX_TRIANGLE_COUNT),
  localparam int IW = $clog2(MAX_VERTEX_COUNT),
  localparam int AW = $clog2(3 * MAX_TRIANGLE_COUNT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [TW:0]   i_num_triangles,
  input  logic          i_rewind,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [IW-1:0] i_wr_data,
  input  logic          i_read_en,
  output logic [IW-1:0] o_index_data [3],
  output logic          o_index_dv,
  output logic          o_index_last,
  output logic          o_busy,
  output logic          o_error
);

  ib_state_t     state_q, state_d;
  logic [TW-1:0] p_q, p_d;
  logic [TW:0]   count_q, count_d;
  logic          zero_q, zero_d;
  logic [IW-1:0] c0_q, c0_d;
  logic [IW-1:0] c1_q, c1_d;
  logic [IW-1:0] data_q [3];
  logic [IW-1:0] data_d [3];
  logic          dv_q, dv_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          busy;
  logic          is_last;
  logic [TW:0]   clamped_count;
  logic [1:0]    corner;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

  assign busy          = (state_q != IB_IDLE);
  assign clamped_count = (i_num_triangles > (TW+1)'(MAX_TRIANGLE_COUNT)) ?
                         (TW+1)'(MAX_TRIANGLE_COUNT) : i_num_triangles;
  assign is_last       = ({1'b0, p_q} == (count_q - (TW+1)'(1)));
  assign rd_addr       = AW'(tri_word_addr(32'(p_q), 32'(corner)));

  index_ram #(
    .DEPTH (3 * MAX_TRIANGLE_COUNT),
    .WIDTH (IW),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (i_wr_en),
    .wr_addr_i (i_wr_addr),
    .wr_data_i (i_wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Corner select for the RAM read; an empty buffer never touches the RAM.
  always_comb begin
    corner = 2'd0;
    rd_en  = 1'b0;
    case (state_q)
      IB_READ0: begin corner = 2'd0; rd_en = !zero_q; end
      IB_READ1: begin corner = 2'd1; rd_en = !zero_q; end
      IB_READ2: begin corner = 2'd2; rd_en = !zero_q; end
      default:  begin corner = 2'd0; rd_en = 1'b0;    end
    endcase
  end

  // Next-state: walk the three corners, then rewind and request arbitration.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    count_d = count_q;
    zero_d  = zero_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    last_d  = last_q;
    err_d   = 1'b0;

    case (state_q)
      IB_IDLE:  state_d = IB_IDLE;
      IB_READ0: state_d = IB_READ1;
      IB_READ1: begin
        c0_d    = rd_data;
        state_d = IB_READ2;
      end
      IB_READ2: begin
        c1_d    = rd_data;
        state_d = IB_CAPTURE;
      end
      IB_CAPTURE: begin
        state_d = IB_IDLE;
        dv_d    = 1'b1;
        if (zero_q) begin
          data_d[0] = '0;
          data_d[1] = '0;
          data_d[2] = '0;
          last_d    = 1'b1;
        end else begin
          data_d[0] = c0_q;
          data_d[1] = c1_q;
          data_d[2] = rd_data;
          last_d    = is_last;
          p_d       = is_last ? '0 : p_q + TW'(1);
        end
      end
      default: state_d = IB_IDLE;
    endcase

    // Rewind abandons any fetch in flight, including its pending capture.
    if (i_rewind) begin
      state_d = IB_IDLE;
      p_d     = '0;
      dv_d    = 1'b0;
      data_d  = data_q;
      last_d  = last_q;
    end

    // A request is accepted from idle or together with a rewind; otherwise it is an error.
    if (i_read_en) begin
      if (busy && !i_rewind) begin
        err_d = 1'b1;
      end else begin
        state_d = IB_READ0;
        count_d = clamped_count;
        zero_d  = (clamped_count == '0);
        err_d   = (clamped_count == '0);
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IB_IDLE;
      p_q     <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
      data_q  <= '{default: '0};
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign o_index_data = data_q;
  assign o_index_dv   = dv_q;
  assign o_index_last = last_q;
  assign o_busy       = busy;
  assign o_error      = err_q;

endmodule

// File: doc/triangle_index_fetcher.md
TRIANGLE_INDEX_FETCHER -- requirements
Module: triangle_index_fetcher

Interface
REQ-001 Parameter MAX_TRIANGLE_COUNT, default 16384, triangle capacity; TW = $clog2(MAX_TRIANGLE_COUNT).
REQ-002 Parameter MAX_VERTEX_COUNT, default 16384, vertex index range; IW = $clog2(MAX_VERTEX_COUNT).
REQ-003 Derived AW = $clog2(3*MAX_TRIANGLE_COUNT), flat index-word address width.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 i_num_triangles  in  TW+1  triangles currently in buffer.
REQ-007 i_rewind  in  1  pulse; read pointer returns to triangle 0.
REQ-008 i_wr_en  in  1  index write strobe from loader.
REQ-009 i_wr_addr  in  AW  flat word address (triangle t, corner c = 3t+c).
REQ-010 i_wr_data  in  IW  vertex index to store.
REQ-011 i_read_en  in  1  request next triangle's three indices.
REQ-012 o_index_data[3]  out  IW each  corners 0..2 of fetched triangle.
REQ-013 o_index_dv  out  1  one-cycle pulse, o_index_data valid.
REQ-014 o_index_last  out  1  fetched triangle is final one; qualified by o_index_dv.
REQ-015 o_busy  out  1  fetch in progress.
REQ-016 o_error  out  1  one-cycle pulse on illegal request.

Function
REQ-017 Storage SHALL be simple dual-port RAM, depth 3*MAX_TRIANGLE_COUNT, width IW, one write port, one registered read port (1-cycle latency).
REQ-018 Write SHALL occur on any cycle with i_wr_en=1, independent of FSM state.
REQ-019 Same-cycle write/read to same address SHALL return old data.
REQ-020 FSM states: IB_IDLE, IB_READ0, IB_READ1, IB_READ2, IB_CAPTURE.
REQ-021 IB_IDLE -> IB_READ0 when i_read_en=1 and i_rewind=0; latches count = min(i_num_triangles, MAX_TRIANGLE_COUNT).
REQ-022 IB_READ0/1/2 SHALL issue RAM addresses 3p, 3p+1, 3p+2 (p = read pointer) one per cycle, advancing unconditionally.
REQ-023 IB_READ1, IB_READ2, IB_CAPTURE SHALL capture returned words into corners 0, 1, 2 respectively; IB_CAPTURE -> IB_IDLE.
REQ-024 o_index_dv SHALL rise exactly 4 cycles after edge sampling i_read_en, high one cycle.
REQ-025 o_index_data SHALL update only with o_index_dv and hold thereafter until next dv.
REQ-026 o_index_last SHALL equal (p == count-1), registered alongside o_index_dv, held with data.
REQ-027 On dv, p SHALL increment; after last triangle p SHALL wrap to 0.
REQ-028 o_busy SHALL be 1 in every state except IB_IDLE.
REQ-029 i_read_en while busy SHALL be ignored and pulse o_error.
REQ-030 i_read_en with count==0 SHALL skip RAM, return zeros with o_index_dv=1, o_index_last=1 at same latency, and pulse o_error.
REQ-031 i_rewind SHALL set p=0; if busy, abort fetch, no dv, return to IB_IDLE.
REQ-032 i_rewind with i_read_en same cycle: rewind wins, then fetch of triangle 0 starts (IB_READ0).
REQ-033 Back-to-back: i_read_en asserted in cycle of o_index_dv SHALL start next fetch immediately (5-cycle throughput).

Reset
REQ-034 rstn low SHALL asynchronously force IB_IDLE, p=0, all outputs 0 (o_index_data all zero); RAM contents not reset.
REQ-035 Reset mid-fetch SHALL abort without dv; first post-reset fetch returns triangle 0.

Structure
REQ-036 ib_state_t enum and word-address helper SHALL live in shared package index_buffer_pkg.
REQ-037 RAM SHALL be sub-module index_ram (parameterised depth/width, inferred BRAM).

Verification
REQ-038 Load 2 triangles {5,6,7},{8,9,10}, count=2, read_en x2 -> dv at +4 cycles each, data {5,6,7} last=0, then {8,9,10} last=1.
REQ-039 Third read_en after REQ-038 -> {5,6,7} last=0 (wrap).
REQ-040 read_en at cycle 2 of a fetch -> o_error pulse, single dv only.
REQ-041 i_rewind during IB_READ1 -> no dv; next read_en returns triangle 0.
REQ-042 count=0, read_en -> dv with {0,0,0}, last=1, o_error=1.
REQ-043 Write address 3 with 42 on same cycle it is read -> old value returned; next fetch returns 42.
